// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Byte-stream loader for the 9-bit instruction memory. It holds
//               the core in reset until the whole image has been written.
//               Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR
//               checksum byte after the image.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int D = 12,
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         wr_en,
    output logic [D-1:0] wr_addr,
    output logic [W-1:0] wr_data,
    output logic         core_reset,
    output logic         load_done,
    output logic         err
);

    localparam logic [16:0] c_max_words = 17'(2 ** D);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_LO,
        S_HDR_HI,
        S_DAT_LO,
        S_DAT_HI,
        S_WR,
        S_DONE,
        S_ERR
`ifdef PROG_LOADER_CHECKSUM_EN
        ,
        S_CHK
`endif
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [15:0]    r_count;
    logic [D:0]     r_words;
    logic [D:0]     w_words_inc;
    logic [W-1:0]   r_wr_data;
    logic [15:0]    w_hdr_count;
    logic           w_accept;
    logic           w_start_ok;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]     r_xor;
`endif

    assign w_words_inc = r_words + 1'b1;
    assign w_hdr_count = {in_data, r_count[7:0]};
    assign w_accept    = in_valid && in_ready;
    assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);

    // All outputs decode from registered state or registered datapath.
    always_comb begin
        in_ready = 1'b0;
        unique case (r_state)
            S_HDR_LO, S_HDR_HI, S_DAT_LO, S_DAT_HI: in_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHK:                                  in_ready = 1'b1;
`endif
            default:                                in_ready = 1'b0;
        endcase
    end

    assign wr_en      = (r_state == S_WR);
    assign core_reset = (r_state != S_DONE);
    assign load_done  = (r_state == S_DONE);
    assign err        = (r_state == S_ERR);
    assign wr_data    = r_wr_data;
    // A full 2**D image leaves the counter at 2**D; the address saturates there.
    assign wr_addr    = r_words[D] ? {D{1'b1}} : r_words[D-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_start_ok) begin
            w_state_next = S_HDR_LO;
        end else begin
            unique case (r_state)
                S_HDR_LO: if (w_accept) w_state_next = S_HDR_HI;
                S_HDR_HI: begin
                    if (w_accept) begin
                        if (w_hdr_count == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            w_state_next = S_CHK;
`else
                            w_state_next = S_DONE;
`endif
                        end else if (17'(w_hdr_count) > c_max_words) begin
                            w_state_next = S_ERR;
                        end else begin
                            w_state_next = S_DAT_LO;
                        end
                    end
                end
                S_DAT_LO: if (w_accept) w_state_next = S_DAT_HI;
                S_DAT_HI: begin
                    if (w_accept) begin
                        w_state_next = (in_data[7:1] != 7'd0) ? S_ERR : S_WR;
                    end
                end
                S_WR: begin
                    if (17'(w_words_inc) == 17'(r_count)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        w_state_next = S_CHK;
`else
                        w_state_next = S_DONE;
`endif
                    end else begin
                        w_state_next = S_DAT_LO;
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (w_accept) begin
                        w_state_next = (in_data == r_xor) ? S_DONE : S_ERR;
                    end
                end
`endif
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= 16'd0;
            r_words   <= '0;
            r_wr_data <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_xor     <= 8'd0;
`endif
        end else if (w_start_ok) begin
            r_words   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_xor     <= 8'd0;
`endif
        end else begin
            unique case (r_state)
                S_HDR_LO: if (w_accept) r_count[7:0]  <= in_data;
                S_HDR_HI: if (w_accept) r_count[15:8] <= in_data;
                S_DAT_LO: begin
                    if (w_accept) begin
                        r_wr_data[7:0] <= in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_xor          <= r_xor ^ in_data;
`endif
                    end
                end
                S_DAT_HI: begin
                    if (w_accept) begin
                        r_wr_data[W-1] <= in_data[0];
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_xor          <= r_xor ^ in_data;
`endif
                    end
                end
                S_WR:     r_words <= w_words_inc;
                default:  ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Randomised scoreboard bench for prog_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int D      = 12;
    localparam int W      = 9;
    localparam int MAXW   = 1 << D;
    localparam int O_INC  = 0;
    localparam int O_DONE = 1;
    localparam int O_ERR  = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic         wr_en;
    logic [D-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic         core_reset;
    logic         load_done;
    logic         err;

    typedef struct packed {
        logic [D-1:0] a;
        logic [W-1:0] d;
    } wr_t;

    wr_t        sb[$];
    logic [7:0] img[$];
    logic [7:0] chk_byte;
    int         total = 0;
    int         bad   = 0;

    prog_loader #(.D(D), .W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .core_reset (core_reset),
        .load_done  (load_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the next expected write.
    always @(negedge clk) begin
        if (!reset && wr_en) begin
            check("wr_in_ready_low", 32'(in_ready), 32'd0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_unexpected: got addr=%0h data=%0h expected no write", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.a));
                check("wr_data", 32'(wr_data), 32'(e.d));
            end
        end
    end

    // Reference model: interprets the byte image and queues the writes it implies.
    task automatic run_model(input int limit, output int used, output int outcome);
        int         cnt;
        int         p;
        logic [7:0] xr;
        outcome = O_INC;
        xr      = 8'h00;
        if (limit < 2) begin
            used = limit;
            return;
        end
        cnt  = int'({img[1], img[0]});
        used = 2;
        if (cnt > MAXW) begin
            outcome = O_ERR;
            return;
        end
        p = 2;
        for (int k = 0; k < cnt; k++) begin
            if (p + 2 > limit) begin
                used = limit;
                return;
            end
            xr = xr ^ img[p] ^ img[p+1];
            if (img[p+1] > 8'd1) begin
                used    = p + 2;
                outcome = O_ERR;
                return;
            end
            sb.push_back(wr_t'({D'(k), img[p+1][0], img[p]}));
            p += 2;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        if (p + 1 > limit) begin
            used = limit;
            return;
        end
        used    = p + 1;
        outcome = (img[p] == xr) ? O_DONE : O_ERR;
`else
        used    = p;
        outcome = O_DONE;
`endif
    endtask

    task automatic add_trailer(input bit corrupt);
        logic [7:0] xr;
        xr = 8'h00;
        for (int i = 2; i < img.size(); i++) xr ^= img[i];
        chk_byte = corrupt ? ~xr : xr;
`ifdef PROG_LOADER_CHECKSUM_EN
        img.push_back(chk_byte);
`endif
    endtask

    task automatic build_image(input int cnt, input int bad_word, input bit corrupt);
        img.delete();
        img.push_back(8'(cnt));
        img.push_back(8'(cnt >> 8));
        for (int k = 0; k < cnt; k++) begin
            img.push_back(8'($urandom));
            img.push_back((k == bad_word) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1)));
        end
        add_trailer(corrupt);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gapmax);
        int n;
        in_valid = 1'b0;
        repeat ($urandom_range(0, gapmax)) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) begin
            total++;
            bad++;
            $display("FAIL byte_timeout: in_ready=%0b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_end(input int outc);
        int n;
        n = 0;
        while (!(load_done || err) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("end_load_done", 32'(load_done), 32'(outc == O_DONE));
        check("end_err", 32'(err), 32'(outc == O_ERR));
        check("end_core_reset", 32'(core_reset), 32'(outc != O_DONE));
        check("end_in_ready", 32'(in_ready), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_load(input int gapmax);
        int used;
        int outc;
        run_model(img.size(), used, outc);
        pulse_start();
        for (int i = 0; i < used; i++) send_byte(img[i], gapmax);
        wait_end(outc);
    endtask

    initial begin
        int used;
        int outc;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Known three-word image
        img = '{8'h03, 8'h00, 8'h12, 8'h00, 8'h34, 8'h01, 8'hFF, 8'h01};
        add_trailer(1'b0);
        do_load(0);

        // Empty image
        img = '{8'h00, 8'h00};
        add_trailer(1'b0);
        do_load(2);

        // Oversize header, then recovery with a valid image
        img = '{8'h01, 8'h10};
        do_load(1);
        build_image(4, -1, 1'b0);
        do_load(2);

        // Bad high byte on word 2
        build_image(5, 2, 1'b0);
        do_load(1);

        // Reset while waiting for the high byte of word 5
        build_image(8, -1, 1'b0);
        run_model(13, used, outc);
        pulse_start();
        for (int i = 0; i < used; i++) send_byte(img[i], 2);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
        check("mid_rst_core_reset", 32'(core_reset), 32'd1);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_load_done", 32'(load_done), 32'd0);
        check("mid_rst_sb", 32'(sb.size()), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        build_image(8, -1, 1'b0);
        do_load(3);

`ifdef PROG_LOADER_CHECKSUM_EN
        build_image(6, -1, 1'b1);
        do_load(1);
`endif

        // Randomised images with random stalls
        for (int t = 0; t < 10; t++) begin
            int nw;
            int bw;
            nw = $urandom_range(1, 24);
            bw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nw - 1) : -1;
            build_image(nw, bw, $urandom_range(0, 4) == 0);
            do_load($urandom_range(0, 4));
        end

        // Largest legal image: last write lands on the top address
        build_image(MAXW, -1, 1'b0);
        do_load(0);
        check("full_wr_addr_hold", 32'(wr_addr), 32'(MAXW - 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
